// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: FSM state encoding, per-stage lock/flush
// pair, and the hard-wired zero register index.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic lock;
        logic flush;
    } stage_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall-cycle and branch-flush event counters. Both wrap modulo 2^32.
module hazard_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    // Free-running counters, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
            if (flush_inc) flush_events <= flush_events + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Outputs are combinational
// from the registered FSM state and the current hazard inputs.
// Optional build macro: HAZARD_PERF_EN enables the performance counters;
// without it both counter ports read zero and no counter flops exist.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 256,
    parameter int MD_MAX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        md_done,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_lock,
    output logic        if_id_lock,
    output logic        if_id_flush,
    output logic        id_ex_lock,
    output logic        id_ex_flush,
    output logic        ex_mem_lock,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_timeout,
    output logic        md_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
);

    localparam int MEM_CNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam int MD_CNT_W  = $clog2(MD_MAX_CYCLES) + 1;
    localparam logic [MEM_CNT_W-1:0] MEM_LIM = MEM_CNT_W'(MEM_TIMEOUT);
    localparam logic [MD_CNT_W-1:0]  MD_LIM  = MD_CNT_W'(MD_MAX_CYCLES);

    hz_state_t            state;
    logic                 md_done_pend;
    logic [MEM_CNT_W-1:0] mem_cnt;
    logic [MD_CNT_W-1:0]  md_cnt;

    logic        memw;
    logic        lu;
    logic        md_fin;
    logic        pc_ctl;
    logic        mwb_fl;
    stage_ctrl_t if_id_ctl;
    stage_ctrl_t id_ex_ctl;
    stage_ctrl_t ex_mem_ctl;

    assign memw   = mem_req & ~mem_ready;
    assign md_fin = md_done | md_done_pend;
    assign lu     = ex_mem_read & (ex_rd != REG_ZERO) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

    // Fixed-priority hazard resolution: reset, mem wait, mul/div, branch, load-use
    always_comb begin
        pc_ctl     = 1'b0;
        mwb_fl     = 1'b0;
        if_id_ctl  = '0;
        id_ex_ctl  = '0;
        ex_mem_ctl = '0;
        if (rst) begin
            if_id_ctl.flush  = 1'b1;
            id_ex_ctl.flush  = 1'b1;
            ex_mem_ctl.flush = 1'b1;
            mwb_fl           = 1'b1;
        end else if (memw) begin
            // Freeze everything upstream of MEM; EX re-presents its requests later
            pc_ctl          = 1'b1;
            if_id_ctl.lock  = 1'b1;
            id_ex_ctl.lock  = 1'b1;
            ex_mem_ctl.lock = 1'b1;
            mwb_fl          = 1'b1;
        end else if ((state == MD_BUSY && !md_fin) ||
                     (state == RUN && ex_md_start && !md_done)) begin
            // Hold the op in EX and bubble MEM until the unit finishes
            pc_ctl           = 1'b1;
            if_id_ctl.lock   = 1'b1;
            id_ex_ctl.lock   = 1'b1;
            ex_mem_ctl.flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_ctl.flush = 1'b1;
            id_ex_ctl.flush = 1'b1;
        end else if (lu) begin
            pc_ctl          = 1'b1;
            if_id_ctl.lock  = 1'b1;
            id_ex_ctl.flush = 1'b1;
        end
    end

    assign pc_lock      = pc_ctl;
    assign if_id_lock   = if_id_ctl.lock;
    assign if_id_flush  = if_id_ctl.flush;
    assign id_ex_lock   = id_ex_ctl.lock;
    assign id_ex_flush  = id_ex_ctl.flush;
    assign ex_mem_lock  = ex_mem_ctl.lock;
    assign ex_mem_flush = ex_mem_ctl.flush;
    assign mem_wb_flush = mwb_fl;

    // FSM, pending-done latch, wait counters and sticky timeout flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            md_done_pend <= 1'b0;
            mem_cnt      <= '0;
            md_cnt       <= '0;
            mem_timeout  <= 1'b0;
            md_timeout   <= 1'b0;
        end else begin
            if (memw) begin
                if (mem_cnt != MEM_LIM) mem_cnt <= mem_cnt + MEM_CNT_W'(1);
                if (mem_cnt == MEM_LIM - MEM_CNT_W'(1)) mem_timeout <= 1'b1;
                // A done pulse cannot be acted on while frozen; remember it
                if (state == MD_BUSY && md_done) md_done_pend <= 1'b1;
            end else begin
                mem_cnt <= '0;
            end

            case (state)
                RUN: begin
                    md_cnt <= '0;
                    if (!memw && ex_md_start && !md_done) state <= MD_BUSY;
                end
                MD_BUSY: begin
                    if (!memw && md_fin) begin
                        state        <= RUN;
                        md_done_pend <= 1'b0;
                        md_cnt       <= '0;
                    end else begin
                        if (md_cnt != MD_LIM) md_cnt <= md_cnt + MD_CNT_W'(1);
                        if (md_cnt == MD_LIM - MD_CNT_W'(1)) md_timeout <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Outside reset, if_id_flush is raised only by an acted-on branch
    hazard_perf_counters u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (pc_ctl),
        .flush_inc    (if_id_ctl.flush),
        .stall_cycles (perf_stall_cycles),
        .flush_events (perf_flush_events)
    );
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected output patterns are
// hand-derived constants. Honors HAZARD_PERF_EN for the counter checks.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic        ex_md_start, md_done, mem_req, mem_ready;
    logic        pc_lock, if_id_lock, if_id_flush, id_ex_lock, id_ex_flush;
    logic        ex_mem_lock, ex_mem_flush, mem_wb_flush, mem_timeout, md_timeout;
    logic [31:0] perf_stall_cycles, perf_flush_events;
    logic [7:0]  outs;

    int n_chk  = 0;
    int n_pass = 0;

    // {pc_lock, if_id_lock, if_id_flush, id_ex_lock, id_ex_flush, ex_mem_lock, ex_mem_flush, mem_wb_flush}
    localparam logic [7:0] O_IDLE = 8'b0000_0000;
    localparam logic [7:0] O_RST  = 8'b0010_1011;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0010_1000;
    localparam logic [7:0] O_MEMW = 8'b1101_0101;
    localparam logic [7:0] O_MD   = 8'b1101_0010;

    always #5 clk = ~clk;

    assign outs = {pc_lock, if_id_lock, if_id_flush, id_ex_lock, id_ex_flush,
                   ex_mem_lock, ex_mem_flush, mem_wb_flush};

    pipeline_hazard_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_use_rs1        (id_use_rs1),
        .id_use_rs2        (id_use_rs2),
        .ex_rd             (ex_rd),
        .ex_mem_read       (ex_mem_read),
        .ex_branch_taken   (ex_branch_taken),
        .ex_md_start       (ex_md_start),
        .md_done           (md_done),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .pc_lock           (pc_lock),
        .if_id_lock        (if_id_lock),
        .if_id_flush       (if_id_flush),
        .id_ex_lock        (id_ex_lock),
        .id_ex_flush       (id_ex_flush),
        .ex_mem_lock       (ex_mem_lock),
        .ex_mem_flush      (ex_mem_flush),
        .mem_wb_flush      (mem_wb_flush),
        .mem_timeout       (mem_timeout),
        .md_timeout        (md_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Inputs are set at a negedge; sample mid-low-phase, then move to next negedge
    task automatic tick(input string tag, input logic [7:0] exp);
        #2;
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        #2;
        chk("rst_outs", {24'd0, outs}, {24'd0, O_RST});
        chk("rst_mem_to", {31'd0, mem_timeout}, 32'd0);
        chk("rst_md_to", {31'd0, md_timeout}, 32'd0);
        chk("rst_perf_st", perf_stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick("idle", O_IDLE);

        // Load-use on rs1, one bubble, then clears once the load leaves EX
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        tick("lu_rs1", O_LU);
        clr();
        tick("lu_clear", O_IDLE);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        tick("lu_x0", O_IDLE);
        clr(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        tick("lu_rs2", O_LU);
        id_use_rs2 = 1'b0;
        tick("lu_unused", O_IDLE);

        // Branch squashes a simultaneous load-use
        clr(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        ex_branch_taken = 1'b1;
        tick("br_lu", O_BR);

        // Mem wait freezes the pipe; branch acts once memory completes
        clr(); ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick("memw_br", O_MEMW);
        mem_ready = 1'b1;
        tick("br_after_memw", O_BR);
        clr();

        // Mul/div: start + 10 busy cycles stalled, done releases same cycle
        ex_md_start = 1'b1;
        tick("md_start", O_MD);
        for (int i = 0; i < 10; i++) tick("md_busy", O_MD);
        md_done = 1'b1;
        tick("md_done", O_IDLE);
        clr();
        tick("md_run", O_IDLE);

        // Single-cycle op: no stall, stays in RUN
        ex_md_start = 1'b1; md_done = 1'b1;
        tick("md_1cyc", O_IDLE);
        clr();
        tick("md_1cyc_run", O_IDLE);

        // md_done during a mem wait is held until the wait ends
        ex_md_start = 1'b1;
        tick("mdp_start", O_MD);
        tick("mdp_busy", O_MD);
        mem_req = 1'b1; mem_ready = 1'b0; md_done = 1'b1;
        tick("mdp_memw0", O_MEMW);
        md_done = 1'b0;
        tick("mdp_memw1", O_MEMW);
        mem_ready = 1'b1;
        tick("mdp_exit", O_IDLE);
        clr();
        tick("mdp_run", O_IDLE);

        // Mem timeout after exactly 256 wait cycles, then sticky
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("mem_to_pre", {31'd0, mem_timeout}, 32'd0);
            tick("memto_frz", O_MEMW);
        end
        chk("mem_to_set", {31'd0, mem_timeout}, 32'd1);
        clr();
        tick("memto_idle", O_IDLE);
        chk("mem_to_sticky", {31'd0, mem_timeout}, 32'd1);

        // MD timeout after 64 busy cycles; FSM keeps waiting
        ex_md_start = 1'b1;
        tick("mdto_start", O_MD);
        ex_md_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("md_to_pre", {31'd0, md_timeout}, 32'd0);
            tick("mdto_busy", O_MD);
        end
        chk("md_to_set", {31'd0, md_timeout}, 32'd1);
        #2;
        chk("mdto_wait", {24'd0, outs}, {24'd0, O_MD});
        // Async reset mid-MD_BUSY, asserted away from any clock edge
        #1 rst = 1'b1;
        #1;
        chk("async_rst_outs", {24'd0, outs}, {24'd0, O_RST});
        chk("async_rst_md_to", {31'd0, md_timeout}, 32'd0);
        chk("async_rst_mem_to", {31'd0, mem_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick("post_rst_run", O_IDLE);

        // Perf: 7 stall cycles (1 load-use + md start + 5 busy) and 2 branches
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        tick("perf_lu", O_LU);
        clr(); ex_md_start = 1'b1;
        tick("perf_md0", O_MD);
        ex_md_start = 1'b0;
        for (int i = 0; i < 5; i++) tick("perf_md", O_MD);
        md_done = 1'b1;
        tick("perf_md_done", O_IDLE);
        clr(); ex_branch_taken = 1'b1;
        tick("perf_br0", O_BR);
        tick("perf_br1", O_BR);
        clr();
        tick("perf_idle", O_IDLE);
`ifdef HAZARD_PERF_EN
        chk("perf_stall", perf_stall_cycles, 32'd7);
        chk("perf_flush", perf_flush_events, 32'd2);
`else
        chk("perf_stall", perf_stall_cycles, 32'd0);
        chk("perf_flush", perf_flush_events, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
